// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: schedule geometry, FSM encodings and the Rcon lookup.
package aes_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // Round constant for the MSB byte of word 0; rounds outside 1..10 contribute nothing.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_round_step.sv
// Combinational AES-128 key-expansion round: previous round key plus round index -> next round key.
module key_round_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  input  logic [3:0]       rcnt_i,
  output logic [KEY_W-1:0] key_o
);

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;
  assign rot_w = {w3[23:0], w3[31:24]};
  assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};

  assign n0 = w0 ^ sub_w ^ {rcon(rcnt_i), 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key-schedule sequencer with an 11-entry round-key table and addressed read port.
// Define KEY_SCHED_CACHE_EN to skip re-expansion when the same cipher key is reloaded.
module key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    keyValid,
  output logic                    keyReady,
  input  logic [KEY_W-1:0]        keyIn,
  input  logic [3:0]              rkAddr,
  output logic [KEY_W-1:0]        rkData,
  output logic [(NR+1)*KEY_W-1:0] roundKeysFlat,
  output logic                    tableValid,
  output logic                    expandDone
);

  state_t           state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [KEY_W-1:0] rk_tbl_q [NR+1];
  logic [KEY_W-1:0] rk_tbl_d [NR+1];
  logic [KEY_W-1:0] rkdata_q, rkdata_d;
  logic             tvalid_q, tvalid_d;
  logic             done_q, done_d;
  logic [KEY_W-1:0] prev_key, step_key;

`ifdef KEY_SCHED_CACHE_EN
  logic [KEY_W-1:0] cache_key_q, cache_key_d;
  logic             cache_vld_q, cache_vld_d;
  logic             hit_q, hit_d;
`endif

  key_round_step u_step (
    .key_i  (prev_key),
    .rcnt_i (round_q),
    .key_o  (step_key)
  );

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    rk_tbl_d = rk_tbl_q;
    tvalid_d = tvalid_q;
    done_d   = 1'b0;
    keyReady = 1'b0;
    prev_key = '0;
    rkdata_d = '0;
`ifdef KEY_SCHED_CACHE_EN
    cache_key_d = cache_key_q;
    cache_vld_d = cache_vld_q;
    hit_d       = 1'b0;
    done_d      = hit_q;
`endif

    for (int i = 0; i < NR; i++) begin
      if (round_q == 4'(i + 1)) prev_key = rk_tbl_q[i];
    end

    // Read mux samples the table before this cycle's write; out-of-range indices read zero.
    for (int i = 0; i <= NR; i++) begin
      if (rkAddr == 4'(i)) rkdata_d = rk_tbl_q[i];
    end

    case (state_q)
      IDLE: begin
        keyReady = 1'b1;
        if (keyValid) begin
`ifdef KEY_SCHED_CACHE_EN
          if (tvalid_q && cache_vld_q && (keyIn == cache_key_q)) begin
            hit_d = 1'b1;
          end else begin
            cache_key_d = keyIn;
            cache_vld_d = 1'b1;
            rk_tbl_d[0] = keyIn;
            round_d     = 4'd1;
            tvalid_d    = 1'b0;
            state_d     = EXPAND;
          end
`else
          rk_tbl_d[0] = keyIn;
          round_d     = 4'd1;
          tvalid_d    = 1'b0;
          state_d     = EXPAND;
`endif
        end
      end
      EXPAND: begin
        for (int i = 1; i <= NR; i++) begin
          if (round_q == 4'(i)) rk_tbl_d[i] = step_key;
        end
        round_d = round_q + 4'd1;
        if (round_q == 4'(NR)) begin
          tvalid_d = 1'b1;
          done_d   = 1'b1;
          round_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      round_q  <= '0;
      for (int i = 0; i <= NR; i++) rk_tbl_q[i] <= '0;
      rkdata_q <= '0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef KEY_SCHED_CACHE_EN
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
      hit_q       <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      rk_tbl_q <= rk_tbl_d;
      rkdata_q <= rkdata_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
`ifdef KEY_SCHED_CACHE_EN
      cache_key_q <= cache_key_d;
      cache_vld_q <= cache_vld_d;
      hit_q       <= hit_d;
`endif
    end
  end

  for (genvar g = 0; g <= NR; g++) begin : g_flat
    assign roundKeysFlat[g*KEY_W +: KEY_W] = rk_tbl_q[g];
  end

  assign rkData     = rkdata_q;
  assign tableValid = tvalid_q;
  assign expandDone = done_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl against FIPS-197 key-expansion vectors.
module tb_key_schedule_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               keyValid;
  logic               keyReady;
  logic [127:0]       keyIn;
  logic [3:0]         rkAddr;
  logic [127:0]       rkData;
  logic [11*128-1:0]  roundKeysFlat;
  logic               tableValid;
  logic               expandDone;

  int checks = 0;
  int errors = 0;

  logic [127:0] fips [11];
  logic [127:0] zero_rk10;
  logic [127:0] exp_q [$];

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [13];

  always #5 clk = ~clk;

  key_schedule_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .keyValid      (keyValid),
    .keyReady      (keyReady),
    .keyIn         (keyIn),
    .rkAddr        (rkAddr),
    .rkData        (rkData),
    .roundKeysFlat (roundKeysFlat),
    .tableValid    (tableValid),
    .expandDone    (expandDone)
  );

  function automatic logic [127:0] rk(input int i);
    return roundKeysFlat[i*128 +: 128];
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Offer a key at the falling edge, wait (bounded) for keyReady, return #1 after the accept edge.
  task automatic accept(input string nm, input logic [127:0] k);
    int t;
    t = 0;
    @(negedge clk);
    keyIn    = k;
    keyValid = 1'b1;
    while (!keyReady && t < 20) begin
      @(negedge clk);
      t++;
    end
    check(nm, 128'(keyReady), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drop_valid();
    @(negedge clk);
    keyValid = 1'b0;
  endtask

  // Count edges until expandDone; note whether tableValid was seen high or low before it.
  task automatic wait_done(output int n, output bit tv_hi, output bit tv_lo);
    n = 0;
    tv_hi = 1'b0;
    tv_lo = 1'b0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (expandDone) break;
      if (tableValid) tv_hi = 1'b1;
      else            tv_lo = 1'b1;
    end
  endtask

  initial begin
    int  n;
    bit  tv_hi, tv_lo;
    bit  held_bad;

    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    for (int i = 0; i < 11; i++) begin
      vecs[i].addr = 4'(i);
      vecs[i].exp  = fips[i];
    end
    vecs[11].addr = 4'd11; vecs[11].exp = '0;
    vecs[12].addr = 4'd15; vecs[12].exp = '0;

    rst      = 1'b1;
    keyValid = 1'b0;
    keyIn    = '0;
    rkAddr   = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  128'(keyReady),     128'd1);
    check("rst_tvalid", 128'(tableValid),   128'd0);
    check("rst_done",   128'(expandDone),   128'd0);
    check("rst_rkdata", rkData,             '0);
    check("rst_flat",   128'(|roundKeysFlat), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 expansion and latency
    accept("t1_accept", fips[0]);
    check("t1_busy", 128'(keyReady), 128'd0);
    drop_valid();
    wait_done(n, tv_hi, tv_lo);
    check("t1_latency", 128'(n), 128'd10);
    check("t1_tv_early", 128'(tv_hi), 128'd0);
    check("t1_tvalid", 128'(tableValid), 128'd1);
    check("t1_ready_back", 128'(keyReady), 128'd1);
    for (int i = 0; i < 11; i++) check($sformatf("t1_rk%0d", i), rk(i), fips[i]);
    @(posedge clk);
    #1;
    check("t1_done_pulse", 128'(expandDone), 128'd0);

    // Read port, scoreboarded one cycle behind the address
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rkAddr = vecs[i].addr;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("t4_rd%0d", vecs[i].addr), rkData, exp_q.pop_front());
    end

`ifdef KEY_SCHED_CACHE_EN
    // Reload of the cached key completes in one cycle without dropping tableValid
    accept("t5_accept", fips[0]);
    check("t5_tv_hold", 128'(tableValid), 128'd1);
    drop_valid();
    wait_done(n, tv_hi, tv_lo);
    check("t5_latency", 128'(n), 128'd1);
    check("t5_tvalid", 128'(tableValid), 128'd1);
    check("t5_rk10", rk(10), fips[10]);
    accept("t5_zero_acc", '0);
    drop_valid();
    wait_done(n, tv_hi, tv_lo);
    check("t5_zero_lat", 128'(n), 128'd10);
    check("t5_zero_rk10", rk(10), zero_rk10);
`else
    // Reload of the same key re-runs the whole expansion
    accept("t6_accept", fips[0]);
    check("t6_tv_drop", 128'(tableValid), 128'd0);
    drop_valid();
    wait_done(n, tv_hi, tv_lo);
    check("t6_latency", 128'(n), 128'd10);
    check("t6_tv_low", 128'(tv_hi), 128'd0);
    check("t6_tvalid", 128'(tableValid), 128'd1);
    for (int i = 0; i < 11; i++) check($sformatf("t6_rk%0d", i), rk(i), fips[i]);
`endif

    // Second key held during EXPAND is taken only when the table completes
    accept("t2_accept", fips[0]);
    @(negedge clk);
    keyIn = '0;
    held_bad = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (expandDone) break;
      if (keyReady || rk(0) !== fips[0]) held_bad = 1'b1;
    end
    check("t2_latency", 128'(n), 128'd10);
    check("t2_held", 128'(held_bad), 128'd0);
    check("t2_ready", 128'(keyReady), 128'd1);
    check("t2_rk10_first", rk(10), fips[10]);
    @(posedge clk);
    #1;
    check("t2_rk0_second", rk(0), '0);
    check("t2_tv_clear", 128'(tableValid), 128'd0);
    drop_valid();
    wait_done(n, tv_hi, tv_lo);
    check("t2_latency2", 128'(n), 128'd10);
    check("t2_rk10_second", rk(10), zero_rk10);

    // Reset in the middle of an expansion
    accept("t3_accept", fips[0]);
    drop_valid();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t3_flat", 128'(|roundKeysFlat), 128'd0);
    check("t3_tvalid", 128'(tableValid), 128'd0);
    check("t3_ready", 128'(keyReady), 128'd1);
    @(posedge clk);
    #1;
    check("t3_rkdata", rkData, '0);
    check("t3_done", 128'(expandDone), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    accept("t3_accept2", fips[0]);
    drop_valid();
    wait_done(n, tv_hi, tv_lo);
    check("t3_latency", 128'(n), 128'd10);
    check("t3_rk1", rk(1), fips[1]);
    check("t3_rk10", rk(10), fips[10]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
